// File: rtl/gpio_pad_ctrl.sv
// Per-pin GPIO pad controller: registered pad drive, synchronised and
// debounced pad return, edge detection and sticky interrupt pending bits.
module gpio_pad_ctrl #(
  parameter int unsigned NUM_PIN = 8,
  parameter int unsigned DEB_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_PIN-1:0] out_i,
  input  logic [NUM_PIN-1:0] oe_i,
  input  logic [NUM_PIN-1:0] pu_i,
  input  logic [NUM_PIN-1:0] deb_en_i,
  input  logic [DEB_W-1:0]   deb_thr_i,
  input  logic [NUM_PIN-1:0] rise_en_i,
  input  logic [NUM_PIN-1:0] fall_en_i,
  input  logic [NUM_PIN-1:0] irq_clr_i,
  output logic [NUM_PIN-1:0] pad_i_o,
  output logic [NUM_PIN-1:0] pad_oen_o,
  output logic [NUM_PIN-1:0] pad_ren_o,
  input  logic [NUM_PIN-1:0] pad_c_i,
  output logic [NUM_PIN-1:0] in_o,
  output logic [NUM_PIN-1:0] irq_pend_o,
  output logic               irq_o
);

  logic [NUM_PIN-1:0] pad_i_q;
  logic [NUM_PIN-1:0] pad_oen_q;
  logic [NUM_PIN-1:0] pad_ren_q;
  logic [NUM_PIN-1:0] s1_q;
  logic [NUM_PIN-1:0] s2_q;
  logic [NUM_PIN-1:0] in_q;
  logic [NUM_PIN-1:0] in_d;
  logic [NUM_PIN-1:0] pend_q;
  logic [NUM_PIN-1:0] pend_d;
  logic [NUM_PIN-1:0] rise;
  logic [NUM_PIN-1:0] fall;
  logic [NUM_PIN-1:0] evt;
  logic [DEB_W-1:0]   cnt_q [NUM_PIN];
  logic [DEB_W-1:0]   cnt_d [NUM_PIN];
  logic [1:0]         wu_q;
  logic [1:0]         wu_d;
  logic               armed;

  assign armed = (wu_q == 2'd3);
  assign wu_d  = armed ? wu_q : wu_q + 2'd1;

  // Counter stays at 0 while debounce is off, so toggling the enable
  // either way always starts the next count from zero.
  always_comb begin
    in_d = in_q;
    for (int k = 0; k < NUM_PIN; k++) begin
      cnt_d[k] = '0;
      if (!armed || !deb_en_i[k]) begin
        in_d[k] = s2_q[k];
      end else if (s2_q[k] != in_q[k]) begin
        if (cnt_q[k] >= deb_thr_i) begin
          in_d[k] = s2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign rise   = in_d & ~in_q;
  assign fall   = ~in_d & in_q;
  assign evt    = armed ? ((rise & rise_en_i) | (fall & fall_en_i))
                        : '0;
  assign pend_d = (pend_q & ~irq_clr_i) | evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_i_q   <= '0;
      pad_oen_q <= '0;
      pad_ren_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      in_q      <= '0;
      pend_q    <= '0;
      wu_q      <= '0;
      for (int k = 0; k < NUM_PIN; k++) cnt_q[k] <= '0;
    end else begin
      pad_i_q   <= out_i;
      pad_oen_q <= oe_i;
      pad_ren_q <= pu_i;
      s1_q      <= pad_c_i;
      s2_q      <= s1_q;
      in_q      <= in_d;
      pend_q    <= pend_d;
      wu_q      <= wu_d;
      for (int k = 0; k < NUM_PIN; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign pad_i_o    = pad_i_q;
  assign pad_oen_o  = pad_oen_q;
  assign pad_ren_o  = pad_ren_q;
  assign in_o       = in_q;
  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model.
module tb_gpio_pad_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] out_v, oe_v, pu_v, deb_en, rise_en, fall_en, clr, pad_c;
  logic [7:0]   thr;
  logic [N-1:0] pad_i, pad_oen, pad_ren, in_v, pend;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [N-1:0] m_pi, m_poen, m_pren, m_in, m_pend, m_d1, m_d2;
  int           m_run [N];
  int           m_since;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.NUM_PIN(N), .DEB_W(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .out_i(out_v), .oe_i(oe_v), .pu_i(pu_v),
    .deb_en_i(deb_en), .deb_thr_i(thr),
    .rise_en_i(rise_en), .fall_en_i(fall_en), .irq_clr_i(clr),
    .pad_i_o(pad_i), .pad_oen_o(pad_oen), .pad_ren_o(pad_ren),
    .pad_c_i(pad_c), .in_o(in_v),
    .irq_pend_o(pend), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: s is the pad value seen two edges ago; a new level is
  // taken once it has differed for more than T consecutive cycles.
  task automatic model_step();
    logic [N-1:0] s, nin, ev;
    if (rst) begin
      m_pi = '0; m_poen = '0; m_pren = '0;
      m_d1 = '0; m_d2 = '0; m_in = '0; m_pend = '0;
      for (int k = 0; k < N; k++) m_run[k] = 0;
      m_since = 0;
    end else begin
      m_pi = out_v; m_poen = oe_v; m_pren = pu_v;
      s   = m_d2;
      nin = m_in;
      for (int k = 0; k < N; k++) begin
        if (m_since < 3 || !deb_en[k]) begin
          nin[k] = s[k];
          m_run[k] = 0;
        end else if (s[k] == m_in[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] > int'(thr)) begin
            nin[k] = s[k];
            m_run[k] = 0;
          end
        end
      end
      ev = '0;
      if (m_since >= 3)
        for (int k = 0; k < N; k++)
          if (nin[k] != m_in[k])
            ev[k] = nin[k] ? rise_en[k] : fall_en[k];
      m_pend = (m_pend & ~clr) | ev;
      m_in = nin;
      m_d2 = m_d1;
      m_d1 = pad_c;
      if (m_since < 3) m_since++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("pad_i", pad_i, m_pi);
    chk("pad_oen", pad_oen, m_poen);
    chk("pad_ren", pad_ren, m_pren);
    chk("in_o", in_v, m_in);
    chk("irq_pend", pend, m_pend);
    chk("irq_o", irq, |m_pend);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    out_v = '0; oe_v = '0; pu_v = '0;
    deb_en = '0; thr = '0; rise_en = '0; fall_en = '0;
    clr = '0; pad_c = '0;
    steps(2);
    chk("rst_pend", pend, 8'h00);
    chk("rst_oen", pad_oen, 8'h00);

    // pad drive and warm-up with pad held high
    rst = 1'b0;
    oe_v = 8'h0F; out_v = 8'h05; pu_v = 8'hF0;
    pad_c = 8'hFF; rise_en = 8'hFF; fall_en = 8'hFF;
    step();
    chk("t1_oen", pad_oen, 8'h0F);
    chk("t1_i", pad_i, 8'h05);
    chk("t1_ren", pad_ren, 8'hF0);
    steps(4);
    chk("t2_in", in_v, 8'hFF);
    chk("t2_pend", pend, 8'h00);

    // undebounced rise on pin0
    rise_en = '0; fall_en = '0;
    pad_c = 8'hFE;
    steps(4);
    rise_en = 8'h01;
    pad_c = 8'hFF;
    steps(2);
    chk("t3_in_early", in_v[0], 1'b0);
    step();
    chk("t3_in", in_v[0], 1'b1);
    chk("t3_pend", pend[0], 1'b1);
    chk("t3_irq", irq, 1'b1);
    clr = 8'h01;
    step();
    clr = '0;
    chk("t3_clr", pend[0], 1'b0);

    // debounce on pin1, T=4
    rise_en = '0;
    deb_en = 8'h02; thr = 8'd4;
    pad_c = 8'hFD;
    steps(3);
    pad_c = 8'hFF;
    steps(8);
    chk("t4_glitch", in_v[1], 1'b1);
    pad_c = 8'hFD;
    steps(6);
    chk("t4_hold6", in_v[1], 1'b1);
    step();
    chk("t4_hold7", in_v[1], 1'b0);

    // set and clear coincide on pin2
    deb_en = '0; fall_en = 8'h04;
    pad_c = 8'hF9;
    steps(2);
    clr = 8'h04;
    step();
    chk("t5_setwins", pend[2], 1'b1);
    step();
    clr = '0;
    chk("t5_clr", pend[2], 1'b0);

    // reset mid-debounce
    fall_en = 8'hFF; rise_en = 8'hFF;
    deb_en = 8'h02; thr = 8'd4;
    pad_c = 8'hFF;
    steps(4);
    rst = 1'b1;
    step();
    chk("t6_in", in_v, 8'h00);
    chk("t6_pend", pend, 8'h00);
    chk("t6_oen", pad_oen, 8'h00);
    rst = 1'b0;
    steps(6);
    chk("t6_nospur", pend, 8'h00);
    chk("t6_in_after", in_v, 8'hFF);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      out_v = N'($urandom); oe_v = N'($urandom); pu_v = N'($urandom);
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) pad_c[k] = ~pad_c[k];
      if ($urandom_range(0, 49) == 0) deb_en = N'($urandom);
      if ($urandom_range(0, 39) == 0) thr = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 29) == 0) rise_en = N'($urandom);
      if ($urandom_range(0, 29) == 0) fall_en = N'($urandom);
      clr = '0;
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) == 0) clr[k] = 1'b1;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
